// File: rtl/neg_cycle_scan.sv
// neg_cycle_scan: after Bellman-Ford relaxation, scans every edge (i,j) of the
// adjacency matrix. Each still-relaxable edge starts a predecessor walk from j.
// The walk takes NODES steps, so it is guaranteed to land on the negative cycle.
// If that vertex is unmarked, the cycle is streamed out vertex by vertex and
// each vertex is marked. A cycle that is already marked is skipped, so each
// distinct cycle is reported once per memory image.
// Optional build macro NEG_CYCLE_PROFIT_EN adds a cycle_weight output. It holds
// the running sum of adjmat[pred(v)][v] over the cycle and is complete on the
// beat that carries vout_last.
module neg_cycle_scan #(
  parameter int NODES    = 16,
  parameter int PRED_W   = 4,
  parameter int WEIGHT_W = 16,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [PRED_W-1:0]        vertmat_addr_a,
  input  logic [PRED_W+WEIGHT_W:0] vertmat_q_a,
  output logic [PRED_W-1:0]        vertmat_addr_b,
  input  logic [PRED_W+WEIGHT_W:0] vertmat_q_b,
  output logic [PRED_W+WEIGHT_W:0] vertmat_data_b,
  output logic                     vertmat_we_b,
  output logic [PRED_W-1:0]        adjmat_row_addr,
  output logic [PRED_W-1:0]        adjmat_col_addr,
  input  logic [WEIGHT_W-1:0]      adjmat_q,
  output logic                     vout_valid,
  input  logic                     vout_ready,
  output logic [PRED_W-1:0]        vout_data,
  output logic                     vout_last,
  output logic                     busy,
  output logic                     cycle_done,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [3:0]               o_dbg_state
`ifdef NEG_CYCLE_PROFIT_EN
  ,
  output logic signed [WEIGHT_W+PRED_W-1:0] cycle_weight
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_SCAN_RD, S_SCAN_CMP, S_SCAN_NXT, S_WALK_RD, S_WALK_STEP,
    S_MARK_RD, S_MARK_CHK, S_ADJ_RD, S_ADJ_ACC, S_EMIT, S_MARK_WR, S_DONE
  } state_t;

  localparam logic [PRED_W-1:0] LAST_IDX  = PRED_W'(NODES - 1);
  localparam logic [PRED_W:0]   LAST_STEP = (PRED_W + 1)'(NODES - 1);

  state_t                r_state;
  logic [PRED_W-1:0]     r_i, r_j, r_v, r_head;
  logic [PRED_W:0]       r_step;
  logic                  r_in_cycle;
  logic [PRED_W-1:0]     r_cur_pred;
  logic [WEIGHT_W-1:0]   r_cur_wt;
  logic [PRED_W-1:0]     r_addr_a, r_addr_b, r_row, r_col;
  logic [PRED_W+WEIGHT_W:0] r_data_b;
  logic                  r_we_b;
  logic                  r_vout_valid, r_vout_last;
  logic [PRED_W-1:0]     r_vout_data;
  logic                  r_busy, r_done;
  logic [CNT_W-1:0]      r_count;
`ifdef NEG_CYCLE_PROFIT_EN
  logic signed [WEIGHT_W+PRED_W-1:0] r_acc, r_cycle_weight, w_acc_nxt;
  logic                  r_last_pend;
`endif

  // Field split of the vertex words {mark, pred, weight}.
  logic                  w_mark_b;
  logic [PRED_W-1:0]     w_pred_b;
  logic [WEIGHT_W-1:0]   w_wt_b, w_wt_a;
  logic                  w_unused_qa;
  logic signed [WEIGHT_W:0] w_sum, w_wj;
  logic                  w_relax, w_row_end, w_scan_end, w_last_chk;
  logic [PRED_W-1:0]     w_i_nxt, w_j_nxt;

  assign w_mark_b    = vertmat_q_b[PRED_W+WEIGHT_W];
  assign w_pred_b    = vertmat_q_b[PRED_W+WEIGHT_W-1:WEIGHT_W];
  assign w_wt_b      = vertmat_q_b[WEIGHT_W-1:0];
  assign w_wt_a      = vertmat_q_a[WEIGHT_W-1:0];
  assign w_unused_qa = ^vertmat_q_a[PRED_W+WEIGHT_W:WEIGHT_W];

  // One extra bit keeps w_i + e exact, so the comparison never wraps.
  assign w_sum   = $signed({w_wt_a[WEIGHT_W-1], w_wt_a}) + $signed({adjmat_q[WEIGHT_W-1], adjmat_q});
  assign w_wj    = $signed({w_wt_b[WEIGHT_W-1], w_wt_b});
  assign w_relax = (adjmat_q != '0) && (w_sum < w_wj);

  assign w_row_end  = (r_j == LAST_IDX);
  assign w_scan_end = w_row_end && (r_i == LAST_IDX);
  assign w_i_nxt    = w_row_end ? r_i + 1'b1 : r_i;
  assign w_j_nxt    = w_row_end ? '0 : r_j + 1'b1;

  // The head is compared with the vertex itself: a self-loop is last on its first beat.
  assign w_last_chk = (w_pred_b == (r_in_cycle ? r_head : r_v));

`ifdef NEG_CYCLE_PROFIT_EN
  // The running sum restarts at the head vertex of each cycle.
  assign w_acc_nxt = ((r_v == r_head) ? '0 : r_acc) +
                     $signed({{PRED_W{adjmat_q[WEIGHT_W-1]}}, adjmat_q});
  assign cycle_weight = r_cycle_weight;
`endif

  // Stream handshake: vout_data and vout_last are held stable while vout_valid
  // is high. A beat transfers on a clock edge where vout_valid && vout_ready.
  // The mark write for that vertex happens in the following cycle.

  // Scan / walk / emit sequencer; all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i <= '0; r_j <= '0; r_v <= '0; r_head <= '0; r_step <= '0;
      r_in_cycle <= 1'b0; r_cur_pred <= '0; r_cur_wt <= '0;
      r_addr_a <= '0; r_addr_b <= '0; r_row <= '0; r_col <= '0;
      r_data_b <= '0; r_we_b <= 1'b0;
      r_vout_valid <= 1'b0; r_vout_last <= 1'b0; r_vout_data <= '0;
      r_busy <= 1'b0; r_done <= 1'b0; r_count <= '0;
`ifdef NEG_CYCLE_PROFIT_EN
      r_acc <= '0; r_cycle_weight <= '0; r_last_pend <= 1'b0;
`endif
    end else begin
      r_we_b <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i <= '0; r_j <= '0; r_count <= '0; r_done <= 1'b0; r_busy <= 1'b1;
            r_addr_a <= '0; r_addr_b <= '0; r_row <= '0; r_col <= '0;
            r_in_cycle <= 1'b0;
            r_state <= S_SCAN_RD;
          end
        end
        S_SCAN_RD: r_state <= S_SCAN_CMP;
        S_SCAN_CMP, S_SCAN_NXT: begin
          if (r_state == S_SCAN_CMP && w_relax) begin
            r_v <= r_j; r_step <= '0; r_addr_b <= r_j;
            r_row <= '0; r_col <= '0;
            r_state <= S_WALK_RD;
          end else if (w_scan_end) begin
            r_busy <= 1'b0; r_done <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_i <= w_i_nxt; r_j <= w_j_nxt;
            r_addr_a <= w_i_nxt; r_addr_b <= w_j_nxt;
            r_row <= w_i_nxt; r_col <= w_j_nxt;
            r_state <= S_SCAN_RD;
          end
        end
        S_WALK_RD: r_state <= S_WALK_STEP;
        S_WALK_STEP: begin
          r_v <= w_pred_b; r_addr_b <= w_pred_b;
          r_step <= r_step + 1'b1;
          r_state <= (r_step == LAST_STEP) ? S_MARK_RD : S_WALK_RD;
        end
        S_MARK_RD: r_state <= S_MARK_CHK;
        S_MARK_CHK: begin
          if (!r_in_cycle && w_mark_b) begin
            r_state <= S_SCAN_NXT;
          end else begin
            r_cur_pred <= w_pred_b; r_cur_wt <= w_wt_b;
            if (!r_in_cycle) begin
              r_head <= r_v; r_in_cycle <= 1'b1;
            end
`ifdef NEG_CYCLE_PROFIT_EN
            r_row <= w_pred_b; r_col <= r_v; r_last_pend <= w_last_chk;
            r_state <= S_ADJ_RD;
`else
            r_vout_valid <= 1'b1; r_vout_data <= r_v; r_vout_last <= w_last_chk;
            r_state <= S_EMIT;
`endif
          end
        end
`ifdef NEG_CYCLE_PROFIT_EN
        S_ADJ_RD: r_state <= S_ADJ_ACC;
        S_ADJ_ACC: begin
          r_acc <= w_acc_nxt; r_cycle_weight <= w_acc_nxt;
          r_vout_valid <= 1'b1; r_vout_data <= r_v; r_vout_last <= r_last_pend;
          r_state <= S_EMIT;
        end
`endif
        S_EMIT: begin
          if (vout_ready) begin
            r_vout_valid <= 1'b0;
            r_we_b <= 1'b1;
            r_data_b <= {1'b1, r_cur_pred, r_cur_wt};
            r_state <= S_MARK_WR;
          end
        end
        S_MARK_WR: begin
          if (r_vout_last) begin
            if (r_count != '1) r_count <= r_count + 1'b1;
            r_in_cycle <= 1'b0;
            r_state <= S_SCAN_NXT;
          end else begin
            r_v <= r_cur_pred; r_addr_b <= r_cur_pred;
            r_state <= S_MARK_RD;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vertmat_addr_a  = r_addr_a;
  assign vertmat_addr_b  = r_addr_b;
  assign vertmat_data_b  = r_data_b;
  assign vertmat_we_b    = r_we_b;
  assign adjmat_row_addr = r_row;
  assign adjmat_col_addr = r_col;
  assign vout_valid      = r_vout_valid;
  assign vout_data       = r_vout_data;
  assign vout_last       = r_vout_last;
  assign busy            = r_busy;
  assign cycle_done      = r_done;
  assign cycle_count     = r_count;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_neg_cycle_scan.sv
// Bench for neg_cycle_scan at NODES=4. Behavioural vertex/adjacency memories
// with one-cycle read latency, directed graphs and a beat scoreboard.
module tb_neg_cycle_scan;
  localparam int NODES    = 4;
  localparam int PRED_W   = 4;
  localparam int WEIGHT_W = 16;
  localparam int CNT_W    = 8;
  localparam int VW       = 1 + PRED_W + WEIGHT_W;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, start;
  logic [PRED_W-1:0]   vertmat_addr_a, vertmat_addr_b;
  logic [VW-1:0]       vertmat_q_a, vertmat_q_b, vertmat_data_b;
  logic                vertmat_we_b;
  logic [PRED_W-1:0]   adjmat_row_addr, adjmat_col_addr;
  logic [WEIGHT_W-1:0] adjmat_q;
  logic                vout_valid, vout_ready, vout_last;
  logic [PRED_W-1:0]   vout_data;
  logic                busy, cycle_done;
  logic [CNT_W-1:0]    cycle_count;
  logic [3:0]          dbg_state;

  neg_cycle_scan #(.NODES(NODES), .PRED_W(PRED_W), .WEIGHT_W(WEIGHT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .vertmat_addr_a(vertmat_addr_a), .vertmat_q_a(vertmat_q_a),
    .vertmat_addr_b(vertmat_addr_b), .vertmat_q_b(vertmat_q_b),
    .vertmat_data_b(vertmat_data_b), .vertmat_we_b(vertmat_we_b),
    .adjmat_row_addr(adjmat_row_addr), .adjmat_col_addr(adjmat_col_addr),
    .adjmat_q(adjmat_q),
    .vout_valid(vout_valid), .vout_ready(vout_ready),
    .vout_data(vout_data), .vout_last(vout_last),
    .busy(busy), .cycle_done(cycle_done), .cycle_count(cycle_count),
    .o_dbg_state(dbg_state)
  );

  // ---------------- memory models ----------------
  logic [VW-1:0]       vmem  [16];
  logic [VW-1:0]       vinit [16];
  logic [WEIGHT_W-1:0] adjm  [16][16];
  logic                load_req;
  int                  wr_cnt = 0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 16; k++) vmem[k] <= vinit[k];
    end else if (vertmat_we_b) begin
      vmem[vertmat_addr_b] <= vertmat_data_b;
      wr_cnt <= wr_cnt + 1;
    end
    vertmat_q_a <= vmem[vertmat_addr_a];
    vertmat_q_b <= vmem[vertmat_addr_b];
    adjmat_q    <= adjm[adjmat_row_addr][adjmat_col_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [4:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int valid_hi = 0;
  logic       rdy_stall;
  logic [3:0] stall_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [4:0] beat(input logic last, input logic [3:0] d);
    return {last, d};
  endfunction

  function automatic logic [VW-1:0] vword(input logic m, input logic [3:0] p, input logic [15:0] w);
    return {m, p, w};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_all();
    for (int k = 0; k < 16; k++) begin
      vinit[k] = vword(1'b0, 4'(k), 16'h0);
      for (int c = 0; c < 16; c++) adjm[k][c] = '0;
    end
  endtask

  task automatic set_vert(input int k, input logic [3:0] p, input logic [15:0] w);
    vinit[k] = vword(1'b0, p, w);
  endtask

  task automatic load_mem();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      n++;
      if (cycle_done) break;
    end
    if (!cycle_done) fail_now(name, $sformatf("cycle_done timeout after %0d cycles", budget));
  endtask

  task automatic wait_stall(input string name, input int budget);
    bit seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (vout_valid && !vout_ready) seen = 1;
    end
    if (!seen) fail_now(name, "stalled beat never presented");
  endtask

  task automatic load_triangle(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    clear_all();
    set_vert(0, 4'd2, w0);
    set_vert(1, 4'd0, w1);
    set_vert(2, 4'd1, w2);
    adjm[0][1] = -16'sd3;
    adjm[1][2] = 16'sd1;
    adjm[2][0] = 16'sd1;
  endtask

  // Monitor: pops one expected beat per handshake.
  task automatic monitor_loop();
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (vout_valid === 1'b1) valid_hi++;
      if (vout_valid === 1'b1 && vout_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat", $sformatf("got data %0d last %0b, expected no beat", vout_data, vout_last));
        end else begin
          e = exp_q.pop_front();
          check("beat", {27'd0, vout_last, vout_data}, {27'd0, e});
        end
      end
    end
  endtask

  // Ready driver: ready high except while the chosen vertex is being presented.
  task automatic ready_loop();
    forever begin
      @(posedge clk); #1;
      vout_ready = (rdy_stall && vout_valid && vout_data == stall_v) ? 1'b0 : 1'b1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, vh0, wr0;
    reset = 1'b1; start = 1'b0; vout_ready = 1'b0; load_req = 1'b0;
    rdy_stall = 1'b0; stall_v = '0;
    clear_all();
    fork
      monitor_loop();
      ready_loop();
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("reset_vout",   {vout_valid, vout_last, vout_data}, 0);
    check("reset_status", {busy, cycle_done, cycle_count}, 0);
    check("reset_mem_b",  {vertmat_we_b, vertmat_data_b}, 0);
    check("reset_addrs",  {vertmat_addr_a, vertmat_addr_b, adjmat_row_addr, adjmat_col_addr}, 0);
    reset = 1'b0;

    // Test 1: no edges -> 2*N*N cycles, no beats.
    clear_all();
    load_mem();
    vh0 = valid_hi;
    pulse_start();
    check("busy_after_start", busy, 1);
    wait_done("noedge_done", 100, n);
    check("noedge_latency", n, 32);
    check("noedge_count", cycle_count, 0);
    check("noedge_busy", busy, 0);
    check("noedge_valid_never", valid_hi - vh0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("noedge_done_hold", {cycle_done, cycle_count}, {1'b1, 8'd0});

    // Test 2: triangle, one relaxable edge (2,0), backpressure on the head beat.
    load_triangle(-16'sd5, -16'sd8, -16'sd7);
    load_mem();
    exp_q.push_back(beat(1'b0, 4'd2));
    exp_q.push_back(beat(1'b0, 4'd1));
    exp_q.push_back(beat(1'b1, 4'd0));
    rdy_stall = 1'b1; stall_v = 4'd2;
    wr0 = wr_cnt;
    pulse_start();
    wait_stall("tri_stall", 400);
    for (int c = 0; c < 5; c++) begin
      check("bp_hold", {vout_valid, vout_last, vout_data}, {1'b1, 1'b0, 4'd2});
      check("bp_no_write", vertmat_we_b, 0);
      @(negedge clk);
    end
    rdy_stall = 1'b0;
    wait_done("tri_done", 600, n);
    check("tri_count", cycle_count, 1);
    check("tri_beats_left", exp_q.size(), 0);
    check("tri_writes", wr_cnt - wr0, 3);
    check("tri_v0", vmem[0], vword(1'b1, 4'd2, -16'sd5));
    check("tri_v1", vmem[1], vword(1'b1, 4'd0, -16'sd8));
    check("tri_v2", vmem[2], vword(1'b1, 4'd1, -16'sd7));
    check("tri_v3", vmem[3], vword(1'b0, 4'd3, 16'h0));

    // Test 3: same triangle, edges (0,1) and (2,0) both relaxable -> one report.
    load_triangle(-16'sd5, -16'sd7, -16'sd7);
    load_mem();
    exp_q.push_back(beat(1'b0, 4'd0));
    exp_q.push_back(beat(1'b0, 4'd2));
    exp_q.push_back(beat(1'b1, 4'd1));
    wr0 = wr_cnt;
    pulse_start();
    wait_done("multi_done", 800, n);
    check("multi_count", cycle_count, 1);
    check("multi_beats_left", exp_q.size(), 0);
    check("multi_writes", wr_cnt - wr0, 3);

    // Test 4: self-loop at vertex 3.
    clear_all();
    set_vert(3, 4'd3, 16'h0);
    adjm[3][3] = -16'sd2;
    load_mem();
    exp_q.push_back(beat(1'b1, 4'd3));
    pulse_start();
    wait_done("self_done", 400, n);
    check("self_count", cycle_count, 1);
    check("self_beats_left", exp_q.size(), 0);
    check("self_v3", vmem[3], vword(1'b1, 4'd3, 16'h0));

    // Test 5: triangle + self-loop; reset while the self-loop beat is stalled.
    load_triangle(-16'sd5, -16'sd8, -16'sd7);
    set_vert(3, 4'd3, 16'h0);
    adjm[3][3] = -16'sd2;
    load_mem();
    exp_q.push_back(beat(1'b0, 4'd2));
    exp_q.push_back(beat(1'b0, 4'd1));
    exp_q.push_back(beat(1'b1, 4'd0));
    rdy_stall = 1'b1; stall_v = 4'd3;
    pulse_start();
    wait_stall("rst_stall", 800);
    check("rst_stalled_beat", {vout_last, vout_data}, {1'b1, 4'd3});
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_vout",   {vout_valid, vout_last, vout_data}, 0);
    check("rst_status", {busy, cycle_done, cycle_count}, 0);
    check("rst_mem_b",  {vertmat_we_b, vertmat_data_b}, 0);
    check("rst_addrs",  {vertmat_addr_a, vertmat_addr_b, adjmat_row_addr, adjmat_col_addr}, 0);
    check("rst_beats_left", exp_q.size(), 0);
    check("rst_v3_unmarked", vmem[3], vword(1'b0, 4'd3, 16'h0));
    @(posedge clk); #1;
    reset = 1'b0;
    rdy_stall = 1'b0;
    exp_q.push_back(beat(1'b1, 4'd3));
    wr0 = wr_cnt;
    pulse_start();
    wait_done("rescan_done", 800, n);
    check("rescan_count", cycle_count, 1);
    check("rescan_beats_left", exp_q.size(), 0);
    check("rescan_writes", wr_cnt - wr0, 1);
    check("rescan_v3", vmem[3], vword(1'b1, 4'd3, 16'h0));
    check("rescan_v0", vmem[0], vword(1'b1, 4'd2, -16'sd5));

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
